// File: rtl/zbuffer_depth_test.sv
// zbuffer_depth_test
//   Depth-test client for a 16-bit z-buffer. Fragments from the rasteriser
//   pass through a two-stage pipeline:
//     S1 : holds the accepted fragment and drives the z-buffer read address.
//     S2 : compares against the returned depth. On a pass it writes the new
//          depth back and emits the pixel.
//   The block also clears the z-buffer. On request it drains in-flight
//   fragments, then sweeps every address to all-ones.
// Ports
//   clk, rst          : single clock, synchronous active-high reset
//   clear_start       : one-cycle clear request (honoured only in RUN)
//   clear_busy        : high while draining or clearing
//   frag_*            : fragment handshake and payload (x, y, z, colour)
//   zb_raddr/zb_rdata : z-buffer read port; data returns one cycle after the address
//   zb_we/waddr/wdata : z-buffer write port
//   pix_*             : framebuffer write strobe with address and colour
//   pass_count        : wrapping count of fragments that passed
//   fail_count        : wrapping count of fragments that failed or were dropped
module zbuffer_depth_test #(
    parameter int unsigned H_RES   = 640,
    parameter int unsigned V_RES   = 480,
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned Z_W     = 16,
    parameter int unsigned COLOR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_start,
    output logic               clear_busy,
    input  logic               frag_valid,
    output logic               frag_ready,
    input  logic [9:0]         frag_x,
    input  logic [8:0]         frag_y,
    input  logic [Z_W-1:0]     frag_z,
    input  logic [COLOR_W-1:0] frag_color,
    output logic [ADDR_W-1:0]  zb_raddr,
    input  logic [Z_W-1:0]     zb_rdata,
    output logic               zb_we,
    output logic [ADDR_W-1:0]  zb_waddr,
    output logic [Z_W-1:0]     zb_wdata,
    output logic               pix_valid,
    output logic [ADDR_W-1:0]  pix_addr,
    output logic [COLOR_W-1:0] pix_color,
    output logic [31:0]        pass_count,
    output logic [31:0]        fail_count
);

    localparam int unsigned       NPIX      = H_RES * V_RES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_CLEAR} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [Z_W-1:0]     z;
        logic [COLOR_W-1:0] color;
    } frag_t;

    state_t            state_q, state_d;
    logic [2:1]        vld_pipe_q, vld_pipe_d;   // [1]=S1, [2]=S2
    logic              s1_oob_q, s1_oob_d;
    frag_t             s1_q, s1_d, s2_q, s2_d;
    logic              fwd_valid_q, fwd_valid_d;
    logic [Z_W-1:0]    fwd_data_q, fwd_data_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [31:0]       pass_count_q, pass_count_d;
    logic [31:0]       fail_count_q, fail_count_d;

    logic              accept, in_range, s1_live, s1_drop, s2_pass, s2_fail;
    logic [ADDR_W-1:0] frag_addr;
    logic [Z_W-1:0]    stored_z;

    always_comb begin
        state_d      = state_q;
        vld_pipe_d   = vld_pipe_q;
        s1_oob_d     = s1_oob_q;
        s1_d         = s1_q;
        s2_d         = s2_q;
        fwd_valid_d  = 1'b0;
        fwd_data_d   = fwd_data_q;
        clr_addr_d   = clr_addr_q;
        zb_we        = 1'b0;
        zb_waddr     = '0;
        zb_wdata     = '0;
        pix_valid    = 1'b0;
        pix_addr     = '0;
        pix_color    = '0;

        // A clear request wins over a fragment offered in the same cycle.
        frag_ready = (state_q == ST_RUN) && !clear_start && !rst;
        accept     = frag_ready && frag_valid;
        in_range   = (ADDR_W'(frag_x) < ADDR_W'(H_RES)) && (ADDR_W'(frag_y) < ADDR_W'(V_RES));
        frag_addr  = ADDR_W'(frag_y) * ADDR_W'(H_RES) + ADDR_W'(frag_x);

        // S1: an out-of-range fragment is counted here and never reaches S2.
        s1_live  = vld_pipe_q[1] && !s1_oob_q;
        s1_drop  = vld_pipe_q[1] && s1_oob_q;
        zb_raddr = s1_live ? s1_q.addr : '0;

        vld_pipe_d[1] = accept;
        if (accept) begin
            s1_d     = '{addr: frag_addr, z: frag_z, color: frag_color};
            s1_oob_d = !in_range;
        end
        vld_pipe_d[2] = s1_live;
        s2_d          = s1_q;

        // S2: the memory read issued in S1 misses a write that lands on the same
        // edge. That write's depth is carried over in fwd_data instead.
        stored_z = fwd_valid_q ? fwd_data_q : zb_rdata;
        s2_pass  = vld_pipe_q[2] && (s2_q.z < stored_z);
        s2_fail  = vld_pipe_q[2] && !s2_pass;

        if (s2_pass && s1_live && (s2_q.addr == s1_q.addr)) begin
            fwd_valid_d = 1'b1;
            fwd_data_d  = s2_q.z;
        end

        if (state_q == ST_CLEAR) begin
            zb_we    = 1'b1;
            zb_waddr = clr_addr_q;
            zb_wdata = '1;
        end else if (s2_pass) begin
            zb_we     = 1'b1;
            zb_waddr  = s2_q.addr;
            zb_wdata  = s2_q.z;
            pix_valid = 1'b1;
            pix_addr  = s2_q.addr;
            pix_color = s2_q.color;
        end

        pass_count_d = pass_count_q + 32'(s2_pass);
        fail_count_d = fail_count_q + 32'(s2_fail) + 32'(s1_drop);

        case (state_q)
            ST_RUN: begin
                if (clear_start) begin
                    state_d      = ST_DRAIN;
                    pass_count_d = '0;
                    fail_count_d = '0;
                end
            end
            ST_DRAIN: begin
                if (vld_pipe_q == 2'b00) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = ST_RUN;
                    clr_addr_d = '0;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign clear_busy = (state_q != ST_RUN);
    assign pass_count = pass_count_q;
    assign fail_count = fail_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            vld_pipe_q   <= '0;
            s1_oob_q     <= 1'b0;
            s1_q         <= '0;
            s2_q         <= '0;
            fwd_valid_q  <= 1'b0;
            fwd_data_q   <= '0;
            clr_addr_q   <= '0;
            pass_count_q <= '0;
            fail_count_q <= '0;
        end else begin
            state_q      <= state_d;
            vld_pipe_q   <= vld_pipe_d;
            s1_oob_q     <= s1_oob_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            fwd_valid_q  <= fwd_valid_d;
            fwd_data_q   <= fwd_data_d;
            clr_addr_q   <= clr_addr_d;
            pass_count_q <= pass_count_d;
            fail_count_q <= fail_count_d;
        end
    end

endmodule

// File: doc/zbuffer_depth_test.md
# zbuffer_depth_test

Depth-test client for the 640x480 16-bit z-buffer memory: accepts rasterised fragments, reads the stored depth through one z-buffer read port, compares, and on pass writes the new depth back through the z-buffer write port and emits the pixel to the framebuffer writer. It also owns z-buffer clearing, sweeping every entry back to 0xFFFF on request. It sits between the rasteriser and the z-buffer memory/framebuffer.

## Interface

Parameters:
- H_RES, 640, horizontal resolution
- V_RES, 480, vertical resolution
- ADDR_W, 19, z-buffer/framebuffer address width
- Z_W, 16, depth width
- COLOR_W, 16, pixel colour width

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- clear_start  in  1  one-cycle request to clear the z-buffer
- clear_busy  out  1  high while draining or clearing
- frag_valid  in  1  fragment present
- frag_ready  out  1  block can accept a fragment this cycle
- frag_x  in  10  pixel column
- frag_y  in  9  pixel row
- frag_z  in  Z_W  fragment depth, smaller is nearer
- frag_color  in  COLOR_W  fragment colour
- zb_raddr  out  ADDR_W  to z-buffer read port (read0)
- zb_rdata  in  Z_W  from z-buffer read data (out0), valid the cycle after the address
- zb_we  out  1  z-buffer write enable
- zb_waddr  out  ADDR_W  z-buffer write address
- zb_wdata  out  Z_W  z-buffer write data
- pix_valid  out  1  one-cycle pixel write strobe, no backpressure
- pix_addr  out  ADDR_W  framebuffer address
- pix_color  out  COLOR_W  framebuffer colour
- pass_count  out  32  fragments that passed, wraps
- fail_count  out  32  fragments that failed or were dropped, wraps

## Operation

- States: RUN, DRAIN, CLEAR. Reset enters RUN.
- RUN: frag_ready = 1. Accept when frag_valid && frag_ready.
- Address = y*H_RES + x (y*512 + y*128 + x for default), computed at accept.
- Out-of-range fragment (x >= H_RES or y >= V_RES): accepted, dropped, fail_count+1 at S1; no read, no write, no pixel.
- Pipeline S1: registered addr/z/colour; zb_raddr = S1 addr (0 when S1 empty).
- S2: stored = forwarded ? fwd_data : zb_rdata. Pass iff frag_z < stored (strict; equal fails).
- Pass: zb_we=1, zb_waddr=addr, zb_wdata=frag_z, pix_valid=1, pix_addr=addr, pix_color=colour, pass_count+1. Fail: no strobes, fail_count+1.
- Forwarding: on the edge S1->S2, if S2 is writing and S2 addr == S1 addr, capture zb_wdata as fwd_data and set forwarded (memory read at that edge returns old data). Back-to-back same-pixel fragments therefore test against the newest depth.
- clear_start in RUN: clear counters, go to DRAIN; ignored in DRAIN/CLEAR. clear_start has priority over a same-cycle fragment, which is not accepted.
- DRAIN: frag_ready=0; in-flight S1/S2 fragments complete normally; when both empty, go CLEAR.
- CLEAR: counter from 0; each cycle zb_we=1, zb_waddr=counter, zb_wdata=0xFFFF; after address H_RES*V_RES-1 (307199) go RUN.
- clear_busy = state != RUN.

## Timing

- Reset values: frag_ready=0 during rst, 1 the cycle after; clear_busy, zb_raddr, zb_we, zb_waddr, zb_wdata, pix_valid, pix_addr, pix_color, pass_count, fail_count all 0; pipeline valids cleared.
- Fragment accepted at edge ending cycle T: zb_raddr valid in T+1; zb_we/pix_valid in T+2; depth lands in memory at end of T+2.
- Throughput: one fragment per cycle in RUN.
- Clear: clear_start at cycle T, clear_busy high from T+1; with empty pipeline first clear write in T+2; 307200 consecutive write cycles; clear_busy low and frag_ready high the cycle after the last write.
- Reset mid-operation (including mid-CLEAR): abort immediately, state RUN, pipeline emptied, partial clear left as-is.
- zb_we is never asserted in RUN except for a passing S2 fragment.

## Test plan

- Memory all 0xFFFF, fragment (x=10,y=2,z=0x1000,colour=0xF800) -> next cycle zb_raddr=1290; following cycle zb_we=1, zb_waddr=1290, zb_wdata=0x1000, pix_valid=1, pix_color=0xF800, pass_count=1.
- Back-to-back same pixel (5,5): z=0x0800 then z=0x0900 -> first writes 0x0800, second fails via forwarding (no zb_we), fail_count=1; third z=0x0700 passes.
- Equal depth: pixel holds 0x1000, fragment z=0x1000 -> no write, no pixel, fail_count+1.
- Out of range x=640,y=0 and x=0,y=480 -> no zb_we, no pix_valid, fail_count+2.
- clear_start with fragment in S2 -> that fragment's write completes, then exactly 307200 writes of 0xFFFF at addresses 0..307199, frag_ready=0 throughout, counters 0, frag_ready=1 after.
- rst asserted at clear address 1000 -> next cycle all outputs 0, clear_busy=0; a subsequent fragment processes normally.
